// File: rtl/onehot_encoder_8to3.sv
// Registered 8-to-3 one-hot encoder with zero/multi-hot flags and a saturating error counter.
// Latency: 1 cycle from input acceptance to out_valid when the output queue is empty.
// Backpressure: a 2-entry output queue; in_ready drops only when both entries are occupied.
module onehot_encoder_8to3 #(
    parameter int ERR_CNT_W     = 8,
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_onehot,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_code,
    output logic                 out_zero,
    output logic                 out_multi,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    // One queued result: the encoded index plus the two error flags.
    typedef struct packed {
        logic [2:0] code;
        logic       zero;
        logic       multi;
    } res_t;

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    res_t       enc;
    res_t       head_q;
    res_t       tail_q;
    logic [1:0] count_q;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;
    logic [3:0] n_set;
    logic       push;
    logic       pop;
    logic       enc_err;

    // Handshake qualifiers. in_ready is forced low during reset so no beat is taken
    // on an edge that is about to clear the queue.
    assign in_ready  = !rst && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign enc_err   = enc.zero || enc.multi;

    // The head entry drives the outputs directly, so outputs are purely registered.
    assign out_code  = head_q.code;
    assign out_zero  = head_q.zero;
    assign out_multi = head_q.multi;

    // Encode the input word: population count plus highest and lowest set-bit positions.
    always_comb begin
        hi_idx = 3'd0;
        lo_idx = 3'd0;
        n_set  = 4'd0;
        enc    = '0;
        for (int i = 0; i < 8; i++) begin
            if (in_onehot[i]) begin
                hi_idx = 3'(i);
                n_set  = n_set + 4'd1;
            end
        end
        for (int i = 7; i >= 0; i--) begin
            if (in_onehot[i]) begin
                lo_idx = 3'(i);
            end
        end
        enc.zero  = (n_set == 4'd0);
        enc.multi = (n_set > 4'd1);
        enc.code  = PRIORITY_HIGH ? hi_idx : lo_idx;
    end

    // Two-entry FIFO. The head register is only rewritten when it is empty or being
    // consumed, which keeps the outputs stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= enc;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= enc;
                    end else if (push) begin
                        tail_q  <= enc;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        count_q <= 2'd1;
                    end
                end
                default: begin
                    count_q <= 2'd0;
                end
            endcase
        end
    end

    // Saturating error counter; a clear in the same cycle as an error beat leaves it at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= (push && enc_err) ? ERR_CNT_W'(1) : '0;
        end else if (push && enc_err && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_onehot_encoder_8to3.sv
// Scoreboard bench for onehot_encoder_8to3: directed scenarios followed by random traffic.
// Expected results are queued at input acceptance and popped at output consumption.
// All DUT sampling happens on the falling clock edge.
module tb_onehot_encoder_8to3;

    localparam int ERR_W = 2;
    localparam bit PRI   = 1'b1;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_onehot;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_code;
    logic             out_zero;
    logic             out_multi;
    logic             err_clr;
    logic [ERR_W-1:0] err_count;

    int checks = 0;
    int passed = 0;

    logic [4:0] exp_q[$];
    int         err_m = 0;
    bit         armed = 0;
    bit         just_rst = 0;
    bit         rand_rdy = 0;

    always #5 clk = ~clk;

    onehot_encoder_8to3 #(.ERR_CNT_W(ERR_W), .PRIORITY_HIGH(PRI)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_onehot (in_onehot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_zero  (out_zero),
        .out_multi (out_multi),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference encoding: {code, zero, multi} from bit counts and logarithms.
    function automatic logic [4:0] model(input logic [7:0] w);
        int         n;
        logic [2:0] c;
        logic [7:0] l;
        n = $countones(w);
        l = w & (~w + 8'd1);
        if (n == 0) c = 3'd0;
        else if (PRI) c = 3'($clog2(int'(w) + 1) - 1);
        else c = 3'($clog2(int'(l)));
        return {c, (n == 0), (n > 1)};
    endfunction

    // Monitor: checks state seen after the last edge, then predicts the coming edge.
    initial begin
        logic       acc;
        logic       con;
        logic [4:0] e;
        forever begin
            @(negedge clk);
            chk("in_ready", in_ready, (!rst && exp_q.size() < 2));
            if (armed) begin
                chk("out_valid", out_valid, (exp_q.size() != 0));
                chk("err_count", err_count, err_m);
            end
            if (just_rst) chk("reset_outputs", {out_code, out_zero, out_multi}, 5'd0);
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            if (rst) begin
                exp_q.delete();
                err_m    = 0;
                armed    = 1;
                just_rst = 1;
            end else begin
                just_rst = 0;
                if (con) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_beat", {out_code, out_zero, out_multi}, e);
                    end
                end
                if (acc) begin
                    e = model(in_onehot);
                    exp_q.push_back(e);
                end
                if (err_clr) err_m = (acc && (e[1] || e[0])) ? 1 : 0;
                else if (acc && (e[1] || e[0]) && err_m < ERR_MAX) err_m++;
            end
        end
    end

    // Random consumer back-pressure during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [7:0] w);
        int n = 0;
        in_onehot = w;
        in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;
        int         n;
        rst = 1'b1; in_valid = 1'b0; in_onehot = 8'h00; out_ready = 1'b0; err_clr = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(3);

        // Walking one-hot stream with a free-running consumer.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 8'(1 << i);
            send(w);
        end
        idle(3);

        // Fill the queue, offer a third beat, then release the consumer.
        out_ready = 1'b0;
        send(8'h08);
        send(8'h10);
        in_onehot = 8'h20;
        in_valid  = 1'b1;
        idle(3);
        out_ready = 1'b1;
        send(8'h20);
        idle(4);

        // Error words.
        send(8'h00);
        send(8'h24);
        idle(3);

        // Counter clear, saturation, and clear coinciding with an error beat.
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        repeat (5) send(8'h00);
        err_clr = 1'b1;
        send(8'h00);
        err_clr = 1'b0;
        idle(3);

        // Reset with a full queue.
        out_ready = 1'b0;
        send(8'h01);
        send(8'h02);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        out_ready = 1'b1;
        send(8'h04);
        send(8'h80);
        idle(3);

        // Random traffic.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       w = 8'h00;
                1:       w = 8'($urandom);
                default: w = 8'(1 << $urandom_range(0, 7));
            endcase
            err_clr = ($urandom_range(0, 15) == 0);
            send(w);
            err_clr = 1'b0;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        idle(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
